barrel_shift_pipe: RTL and testbench

BARREL_SHIFT_PIPE -- requirements
Module: barrel_shift_pipe

---
 rtl/barrel_shift_pipe.sv | 142 ++++++++++++++
 tb/tb_barrel_shift_pipe.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/barrel_shift_pipe.sv
// barrel_shift_pipe: pipelined barrel shifter with a valid/ready stream interface.
// One stage per shift-amount bit; stage k shifts by 2^k when its shamt bit is set.
// Modes: 00 logical right, 01 arithmetic right, 10 logical left, 11 rotate right.
// Optional macro BARREL_SHIFT_STICKY_EN: carries an OR of bits discarded by right
// shifts through the pipe; without it the sticky output is tied to 0.
module barrel_shift_pipe #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data,
    input  logic [SHW-1:0]   shamt,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic             sticky
);

    // One shift step by a fixed amount in the selected mode.
    function automatic logic [WIDTH-1:0] shift_stage(input logic [WIDTH-1:0] d,
                                                      input logic [1:0]       m,
                                                      input int unsigned      amt);
        logic signed [WIDTH-1:0] ds;
        logic signed [WIDTH-1:0] ar;
        logic        [WIDTH-1:0] r;
        ds = d;
        ar = ds >>> amt;
        case (m)
            2'b00:   r = d >> amt;
            2'b01:   r = ar;
            2'b10:   r = d << amt;
            default: r = (d >> amt) | (d << (WIDTH - amt));
        endcase
        return r;
    endfunction

    // OR of the low bits that a right shift by amt pushes out of the word.
    function automatic logic discard_or(input logic [WIDTH-1:0] d,
                                        input int unsigned      amt);
        logic [WIDTH-1:0] mask;
        mask = {WIDTH{1'b1}} >> (WIDTH - amt);
        return |(d & mask);
    endfunction

    // The whole pipe moves together; the output register frees up when consumed.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        localparam int unsigned AMT = 1 << k;

        logic [WIDTH-1:0] d_in;
        logic [WIDTH-1:0] d_nxt;
        logic [SHW-1:0]   s_in;
        logic [1:0]       m_in;
        logic             v_in;

        logic [WIDTH-1:0] data_p;
        logic [SHW-1:0]   sh_p;
        logic [1:0]       mode_p;
        logic             vld_p;

        if (k == 0) begin : g_src
            assign d_in = data;
            assign s_in = shamt;
            assign m_in = mode;
            assign v_in = in_valid;
        end else begin : g_src
            assign d_in = g_stage[k-1].data_p;
            assign s_in = g_stage[k-1].sh_p;
            assign m_in = g_stage[k-1].mode_p;
            assign v_in = g_stage[k-1].vld_p;
        end

        // Shift by 2^k when the lowest remaining shamt bit is set.
        always_comb begin
            d_nxt = d_in;
            if (s_in[0]) d_nxt = shift_stage(d_in, m_in, AMT);
        end

        // Stage register; shamt is shifted down so each stage consumes bit 0.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld_p  <= 1'b0;
                data_p <= '0;
                sh_p   <= '0;
                mode_p <= 2'b00;
            end else if (adv) begin
                vld_p  <= v_in;
                data_p <= d_nxt;
                sh_p   <= s_in >> 1;
                mode_p <= m_in;
            end
        end

`ifdef BARREL_SHIFT_STICKY_EN
        logic st_in;
        logic st_nxt;
        logic sticky_p;

        if (k == 0) begin : g_st_src
            assign st_in = 1'b0;
        end else begin : g_st_src
            assign st_in = g_stage[k-1].sticky_p;
        end

        // Accumulate discarded bits only for the two right-shift modes.
        always_comb begin
            st_nxt = st_in;
            if (s_in[0] && !m_in[1]) st_nxt = st_in | discard_or(d_in, AMT);
        end

        // Sticky register travels with the data of this stage.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sticky_p <= 1'b0;
            end else if (adv) begin
                sticky_p <= st_nxt;
            end
        end
`endif
    end

    assign out_valid = g_stage[SHW-1].vld_p;
    assign q         = g_stage[SHW-1].data_p;

`ifdef BARREL_SHIFT_STICKY_EN
    assign sticky = g_stage[SHW-1].sticky_p;
`else
    assign sticky = 1'b0;
`endif

    // Last stage's shamt and mode have no consumer downstream.
    logic unused_tail;
    assign unused_tail = ^{g_stage[SHW-1].sh_p, g_stage[SHW-1].mode_p};

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Testbench for barrel_shift_pipe (WIDTH=8): scoreboard of expected results,
// directed vectors, full mode/shamt sweep, stall stream and mid-flight reset.
module tb_barrel_shift_pipe;

    localparam int W = 8;
    localparam int S = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] data;
    logic [S-1:0] shamt;
    logic [1:0]   mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] q;
    logic         sticky;

    barrel_shift_pipe #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .data     (data),
        .shamt    (shamt),
        .mode     (mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .q        (q),
        .sticky   (sticky)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] q;
        logic         s;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bit-by-bit reference of the shift result.
    function automatic exp_t model(input logic [W-1:0] d, input int sh, input logic [1:0] m);
        exp_t e;
        int   j;
        e.q = '0;
        e.s = 1'b0;
        for (int i = 0; i < W; i++) begin
            case (m)
                2'b00: begin j = i + sh; e.q[i] = (j < W) ? d[j % W] : 1'b0; end
                2'b01: begin j = i + sh; e.q[i] = (j < W) ? d[j % W] : d[W-1]; end
                2'b10: begin j = i - sh; e.q[i] = (j >= 0) ? d[(j + W) % W] : 1'b0; end
                default: e.q[i] = d[(i + sh) % W];
            endcase
        end
`ifdef BARREL_SHIFT_STICKY_EN
        if (!m[1]) for (int i = 0; i < sh; i++) e.s = e.s | d[i];
`endif
        return e;
    endfunction

    // Offer one beat starting just after a rising edge; push expectation on acceptance.
    task automatic send(input logic [W-1:0] d, input int sh, input logic [1:0] m);
        bit accepted = 0;
        data     = d;
        shamt    = S'(sh);
        mode     = m;
        in_valid = 1'b1;
        for (int n = 0; n < 200 && !accepted; n++) begin
            @(negedge clk);
            if (in_ready) begin
                sbq.push_back(model(d, sh, m));
                accepted = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!accepted) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && sbq.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", 32'(sbq.size()), 32'd0);
    endtask

    // Output monitor: pops the scoreboard on each consumed beat, checks stall stability.
    logic         held = 1'b0;
    logic [W-1:0] held_q;
    logic         held_s;
    exp_t         got;
    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_q", 32'(q), 32'(held_q));
                check("hold_sticky", 32'(sticky), 32'(held_s));
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    check("spurious_beat", 32'd1, 32'd0);
                end else begin
                    got = sbq.pop_front();
                    check("q", 32'(q), 32'(got.q));
                    check("sticky", 32'(sticky), 32'(got.s));
                end
            end
            held   = out_valid && !out_ready;
            held_q = q;
            held_s = sticky;
        end
    end

    logic [W-1:0] rd;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        data      = '0;
        shamt     = '0;
        mode      = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_q", 32'(q), 32'd0);
        check("rst_sticky", 32'(sticky), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Directed vectors, including shamt=0 in every mode.
        send(8'hB4, 4, 2'b00);
        send(8'hB4, 2, 2'b01);
        send(8'hB4, 3, 2'b11);
        send(8'h0F, 5, 2'b10);
        send(8'hB4, 3, 2'b00);
        send(8'hB4, 2, 2'b00);
        send(8'hA5, 0, 2'b00);
        send(8'hA5, 0, 2'b01);
        send(8'hA5, 0, 2'b10);
        send(8'hA5, 0, 2'b11);
        drain();

        // Latency: result appears on the third edge counting the accepting edge.
        send(8'h3C, 1, 2'b01);
        @(negedge clk);
        check("lat_c1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_c2", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_c3", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        drain();

        // Every mode and shift amount on random operands.
        for (int m = 0; m < 4; m++) begin
            for (int s = 0; s < 8; s++) begin
                rd = 8'($urandom());
                send(rd, s, 2'(m));
            end
        end
        drain();

        // Ten back-to-back beats with the consumer stalled for five cycles.
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    rd = 8'($urandom());
                    send(rd, i % 8, 2'(i % 4));
                end
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                @(negedge clk);
                check("stall_in_ready", 32'(in_ready), 32'd0);
                check("stall_out_valid", 32'(out_valid), 32'd1);
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two beats in flight: neither may emerge.
        send(8'h81, 1, 2'b00);
        send(8'h42, 2, 2'b10);
        rst_n = 1'b0;
        sbq.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("flush_out_valid", 32'(out_valid), 32'd0);
        end
        check("flush_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Pipe still works after the flush.
        send(8'hB4, 2, 2'b01);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
